// File: rtl/commit_tag_freelist.sv
// Committed alias table plus circular free-tag FIFO between ROB commit and rename.
// Displaced tags are pushed at tail; rename allocates at specHead; a flush rewinds specHead to comHead.
module commit_tag_freelist #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned NUM_NAMES = 32,
  parameter int unsigned NUM_TAGS  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      IN_comValid,
  input  logic [WIDTH-1:0][5:0] IN_comNmDst,
  input  logic [WIDTH-1:0][6:0] IN_comTagDst,
  input  logic                  IN_flush,
  input  logic [WIDTH-1:0]      IN_allocReq,
  output logic [WIDTH-1:0][5:0] OUT_allocTag,
  output logic                  OUT_allocStall,
  output logic [5:0]            OUT_freeCount
);
  localparam int unsigned FL_DEPTH = NUM_TAGS - NUM_NAMES;
  localparam int unsigned IDX_W    = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;
  localparam int unsigned NM_W     = $clog2(NUM_NAMES);

  logic [6:0]       rat_c [NUM_NAMES];
  logic [5:0]       fifo  [FL_DEPTH];
  logic [PTR_W-1:0] tail, spec_head, com_head;

  logic [WIDTH-1:0]            lane_act, lane_push, lane_adv;
  logic [WIDTH-1:0][6:0]       old_tag;
  logic [WIDTH-1:0][PTR_W-1:0] push_ptr;
  logic [PTR_W-1:0]            push_cnt, adv_cnt;
  logic [PTR_W-1:0]            req_cnt, free_cnt, occ;

  // Old tag of a lane is forwarded from the newest older lane writing the same name.
  always_comb begin
    lane_act  = '0;
    lane_push = '0;
    lane_adv  = '0;
    old_tag   = '0;
    push_ptr  = '0;
    push_cnt  = '0;
    adv_cnt   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_act[i] = IN_comValid[i] && (IN_comNmDst[i] != '0);
      old_tag[i]  = rat_c[IN_comNmDst[i][NM_W-1:0]];
      for (int unsigned j = 0; j < i; j++) begin
        if (lane_act[j] && (IN_comNmDst[j] == IN_comNmDst[i]))
          old_tag[i] = IN_comTagDst[j];
      end
      lane_push[i] = lane_act[i] && !old_tag[i][6];
      lane_adv[i]  = lane_act[i] && !IN_comTagDst[i][6];
      push_ptr[i]  = tail + push_cnt;
      if (lane_push[i]) push_cnt = push_cnt + PTR_W'(1);
      if (lane_adv[i])  adv_cnt  = adv_cnt + PTR_W'(1);
    end
  end

  always_comb begin
    req_cnt      = '0;
    OUT_allocTag = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      OUT_allocTag[i] = fifo[IDX_W'(spec_head + req_cnt)];
      if (IN_allocReq[i]) req_cnt = req_cnt + PTR_W'(1);
    end
    free_cnt       = tail - spec_head;
    occ            = tail - com_head;
    OUT_allocStall = (req_cnt > free_cnt) || IN_flush;
    OUT_freeCount  = 6'(free_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NAMES; i++) rat_c[i] <= 7'(i);
      for (int unsigned k = 0; k < FL_DEPTH; k++)  fifo[k]  <= 6'(NUM_NAMES + k);
      tail      <= PTR_W'(FL_DEPTH);
      spec_head <= '0;
      com_head  <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (lane_act[i])  rat_c[IN_comNmDst[i][NM_W-1:0]] <= IN_comTagDst[i];
        if (lane_push[i]) fifo[push_ptr[i][IDX_W-1:0]]   <= old_tag[i][5:0];
      end
      tail     <= tail + push_cnt;
      com_head <= com_head + adv_cnt;
      if (IN_flush)
        spec_head <= com_head + adv_cnt;
      else if (!OUT_allocStall)
        spec_head <= spec_head + req_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((push_cnt == '0) || ({1'b0, free_cnt} + {1'b0, push_cnt} <= (PTR_W+1)'(FL_DEPTH)))
        else $error("push into a full free list");
      assert (occ <= PTR_W'(FL_DEPTH))
        else $error("tail - comHead exceeds free-list depth");
    end
  end
endmodule

// File: tb/tb_commit_tag_freelist.sv
// Randomized bench for commit_tag_freelist against a queue-based free-list and RAT model.
module tb_commit_tag_freelist;
  localparam int W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      com_valid;
  logic [W-1:0][5:0] com_nm;
  logic [W-1:0][6:0] com_tag;
  logic              flush;
  logic [W-1:0]      alloc_req;
  logic [W-1:0][5:0] alloc_tag;
  logic              alloc_stall;
  logic [5:0]        free_count;

  always #5 clk = ~clk;

  commit_tag_freelist #(.WIDTH(3), .NUM_NAMES(32), .NUM_TAGS(64)) dut (
    .clk(clk), .rst(rst),
    .IN_comValid(com_valid), .IN_comNmDst(com_nm), .IN_comTagDst(com_tag),
    .IN_flush(flush), .IN_allocReq(alloc_req),
    .OUT_allocTag(alloc_tag), .OUT_allocStall(alloc_stall), .OUT_freeCount(free_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: m_free holds tags from comHead to tail in order; m_spec = tags handed out but uncommitted.
  int m_rat [32];
  int m_free [$];
  int m_spec;
  int inflight [$];

  task automatic check(input string tag, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_free.delete();
    for (int k = 0; k < 32; k++) m_free.push_back(32 + k);
    m_spec = 0;
    inflight.delete();
  endtask

  task automatic idle();
    com_valid = '0;
    com_nm    = '0;
    com_tag   = '0;
    flush     = 1'b0;
    alloc_req = '0;
  endtask

  task automatic commit_lane(input int lane, input int name);
    com_valid[lane] = 1'b1;
    com_nm[lane]    = 6'(name);
    com_tag[lane]   = 7'(inflight.pop_front());
  endtask

  // Applies the current inputs for one clock, checking outputs mid-cycle.
  task automatic cycle();
    int n, p, exp_free, old, nm;
    bit exp_stall;
    int granted [$];
    @(negedge clk);
    if (!rst) begin
      exp_free  = m_free.size() - m_spec;
      n         = $countones(alloc_req);
      exp_stall = (n > exp_free) || flush;
      check("free_count", free_count, exp_free);
      check("alloc_stall", alloc_stall, int'(exp_stall));
      p = 0;
      for (int i = 0; i < W; i++) begin
        if (alloc_req[i]) begin
          if (!exp_stall) begin
            check($sformatf("alloc_tag%0d", i), alloc_tag[i], m_free[m_spec + p]);
            granted.push_back(m_free[m_spec + p]);
          end
          p++;
        end
      end
      for (int i = 0; i < W; i++) begin
        nm = int'(com_nm[i]);
        if (com_valid[i] && nm != 0) begin
          old = m_rat[nm];
          m_rat[nm] = int'(com_tag[i]);
          if (old < 64) m_free.push_back(old);
          if (com_tag[i] < 64) begin
            void'(m_free.pop_front());
            m_spec--;
          end
        end
      end
      if (flush) begin
        m_spec = 0;
        inflight.delete();
      end else if (!exp_stall) begin
        m_spec += n;
        foreach (granted[g]) inflight.push_back(granted[g]);
      end
    end
    @(posedge clk);
    if (rst) model_reset();
    #1;
  endtask

  initial begin
    int r;
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_free", free_count, 32);
    check("reset_stall", alloc_stall, 0);

    alloc_req = 3'b111; cycle();
    check("free_after_3", free_count, 29);

    idle(); commit_lane(0, 5); cycle();
    idle(); commit_lane(0, 7); commit_lane(1, 7); cycle();

    idle();
    repeat (10) begin alloc_req = 3'b111; cycle(); end
    alloc_req = 3'b001; cycle();
    check("free_one_left", free_count, 1);
    alloc_req = 3'b011; cycle();
    alloc_req = 3'b010; cycle();
    alloc_req = 3'b100; cycle();

    while (inflight.size() != 0) begin
      idle();
      for (int i = 0; i < W; i++)
        if (inflight.size() != 0) commit_lane(i, $urandom_range(1, 31));
      cycle();
    end

    idle(); alloc_req = 3'b011; cycle();
    idle(); alloc_req = 3'b110; cycle();
    idle(); commit_lane(0, 9); flush = 1'b1; alloc_req = 3'b001; cycle();
    idle(); cycle();

    // x0 with a physical tag must be ignored; name 3 goes immediate then is remapped in the same cycle.
    idle(); alloc_req = 3'b001; cycle();
    idle();
    com_valid = 3'b011; com_nm[0] = 6'd0; com_tag[0] = 7'd20;
    com_nm[1] = 6'd3; com_tag[1] = 7'h40;
    commit_lane(2, 3);
    cycle();
    idle(); cycle();

    repeat (1500) begin
      idle();
      alloc_req = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < W; i++) begin
        r = $urandom_range(0, 3);
        if (r != 0 && inflight.size() != 0)
          commit_lane(i, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : $urandom_range(1, 31));
        else if (r == 0) begin
          com_valid[i] = 1'($urandom_range(0, 1));
          com_nm[i]    = 6'd0;
          com_tag[i]   = 7'($urandom_range(0, 127));
        end
      end
      cycle();
    end

    idle();
    alloc_req = 3'b111; commit_lane(0, 4); rst = 1'b1;
    cycle();
    rst = 1'b0; idle();
    check("midrun_reset_free", free_count, 32);
    alloc_req = 3'b111; cycle();
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
